// File: rtl/command_frame_controller.sv
// command_frame_controller
//   Receives two-byte command frames (code, address) from a UART receiver,
//   validates them, issues a one-cycle command strobe for good frames, waits
//   for the two-byte sensor reply and returns it through a byte-wide UART
//   transmitter handshake. Bad frames are answered with {0xFF, 0xFF}.
//
// Parameters
//   TIMEOUT_CYCLES : inter-byte (and optional response) timeout in clock cycles
//   MAX_ADDR       : highest legal sensor address
//
// Ports
//   clock, reset               : system clock, asynchronous active-high reset
//   rx_valid, rx_byte          : received byte strobe and data
//   cmd_valid, cmd_code/addr   : validated command strobe and fields
//   resp_valid, resp_hi/lo     : sensor reply strobe and bytes
//   tx_start, tx_byte, tx_done : transmitter handshake
//   busy                       : high whenever not idle
//   frame_error                : sticky error for the last frame
//
// Optional feature
//   RESP_TIMEOUT_EN : when defined, WAIT_RESP gives up after TIMEOUT_CYCLES
//                     and answers {0xEE, 0xEE} with frame_error set.
module command_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MAX_ADDR       = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_addr,
  input  logic       resp_valid,
  input  logic [7:0] resp_hi,
  input  logic [7:0] resp_lo,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       busy,
  output logic       frame_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitAddr,
    StIssue,
    StWaitResp,
    StSendHi,
    StWaitHi,
    StSendLo,
    StWaitLo
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      code_q, code_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            frame_good;

  // Expires on the last cycle of the window so the exit edge lands exactly
  // TIMEOUT_CYCLES cycles after state entry.
  assign timeout    = (cnt_q >= CntLast);
  assign frame_good = (code_q <= 8'h06) && (32'(rx_byte) <= MAX_ADDR);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    cmd_valid = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          code_d  = rx_byte;
          state_d = StWaitAddr;
        end
      end
      StWaitAddr: begin
        if (rx_valid) begin
          addr_d = rx_byte;
          if (frame_good) begin
            err_d   = 1'b0;
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            hi_d    = 8'hFF;
            lo_d    = 8'hFF;
            state_d = StSendHi;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = 8'h00;
          state_d = StIdle;
        end
      end
      StIssue: begin
        cmd_valid = 1'b1;
        state_d   = StWaitResp;
      end
      StWaitResp: begin
        if (resp_valid) begin
          hi_d    = resp_hi;
          lo_d    = resp_lo;
          state_d = StSendHi;
        end
`ifdef RESP_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          hi_d    = 8'hEE;
          lo_d    = 8'hEE;
          state_d = StSendHi;
        end
`endif
      end
      StSendHi: begin
        tx_byte  = hi_q;
        tx_start = 1'b1;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        tx_byte = hi_q;
        if (tx_done) state_d = StSendLo;
      end
      StSendLo: begin
        tx_byte  = lo_q;
        tx_start = 1'b1;
        state_d  = StWaitLo;
      end
      StWaitLo: begin
        tx_byte = lo_q;
        if (tx_done) state_d = StIdle;
      end
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= 8'h00;
      addr_q  <= 8'h00;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_code    = code_q;
  assign cmd_addr    = addr_q;
  assign busy        = (state_q != StIdle);
  assign frame_error = err_q;

endmodule
